// File: rtl/mat_inv_pkg.sv
// mat_inv_pkg: shared widths, fraction counts and FSM state type for the
// 2x2 symmetric matrix inverter (mat_inv) and its restoring divider.
package mat_inv_pkg;

  // Input element widths: sig0 Q21.0, sig1 Q16.4, sig2 Q24.8
  localparam int SIG0_W = 21;
  localparam int SIG1_W = 20;
  localparam int SIG2_W = 32;

  // Output widths: out0 Q16.16, out1 Q4.16, out2 Q5.16 (all signed)
  localparam int OUT0_W = 32;
  localparam int OUT1_W = 20;
  localparam int OUT2_W = 21;

  // Fraction counts
  localparam int FRAC_SIG1 = 4;
  localparam int FRAC_SIG2 = 8;
  localparam int FRAC_OUT  = 16;

  // Datapath widths
  localparam int DVD_W = 48;  // dividend
  localparam int DVS_W = 54;  // divisor / determinant
  localparam int QUO_W = 32;  // quotient
  localparam int CNT_W = 5;   // iteration counter

  // Dividend alignment: every numerator is brought to 24 fraction bits so
  // that dividing by D (8 fraction bits) leaves 16 fraction bits.
  localparam int SH0 = FRAC_OUT;
  localparam int SH1 = FRAC_OUT + FRAC_SIG2 - FRAC_SIG1;
  localparam int SH2 = FRAC_OUT + FRAC_SIG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DET  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mat_inv_div.sv
// mat_inv_div: one-quotient-bit-per-cycle restoring divider.
//   clk, rst_n : clock, async active-low reset
//   init       : load dividend, clear state, latch overflow flag
//   step       : produce one quotient bit (MSB first)
//   dividend   : DVD_W-bit unsigned numerator
//   divisor    : DVS_W-bit unsigned divisor (must be valid on init and step)
//   quotient   : QUO_W-bit truncated quotient, valid after QUO_W steps
//   overflow   : true quotient does not fit in QUO_W bits
module mat_inv_div
  import mat_inv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             step,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [QUO_W-1:0] quotient,
  output logic             overflow
);

  logic [DVS_W-1:0] rem_q, rem_d;
  // Low dividend bits shift out of the top while quotient bits shift in.
  logic [QUO_W-1:0] lo_q, lo_d;
  logic             ovf_q, ovf_d;
  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   diff;
  logic             ge;

  always_comb begin
    trial = {rem_q, lo_q[QUO_W-1]};
    ge    = (trial >= {1'b0, divisor});
    diff  = trial - {1'b0, divisor};
    rem_d = rem_q;
    lo_d  = lo_q;
    ovf_d = ovf_q;
    if (init) begin
      rem_d = DVS_W'(dividend[DVD_W-1:QUO_W]);
      lo_d  = dividend[QUO_W-1:0];
      ovf_d = (DVS_W'(dividend[DVD_W-1:QUO_W]) >= divisor);
    end else if (step) begin
      rem_d = ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
      lo_d  = {lo_q[QUO_W-2:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      lo_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      lo_q  <= lo_d;
      ovf_q <= ovf_d;
    end
  end

  assign quotient = lo_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/mat_inv.sv
// mat_inv: sequential inverse of the symmetric matrix [[sig0, sig1], [sig1, sig2]].
//   clk, rst_n      : clock, async active-low reset
//   start           : level request, sampled in IDLE
//   sig0/sig1/sig2  : matrix elements (Q21.0, Q16.4, Q24.8, unsigned)
//   out0/out1/out2  : inverse entries sig2/D, -sig1/D, sig0/D (signed Q.16)
//   o_valid         : one-cycle pulse when outputs update
// Optional build macro MAT_INV_DEBUG_EN adds:
//   det      : registered determinant D (signed, scaled by 2^8)
//   singular : D <= 0 at the most recent completion
module mat_inv
  import mat_inv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIG0_W-1:0] sig0,
  input  logic [SIG1_W-1:0] sig1,
  input  logic [SIG2_W-1:0] sig2,
  output logic [OUT0_W-1:0] out0,
  output logic [OUT1_W-1:0] out1,
  output logic [OUT2_W-1:0] out2,
  output logic              o_valid
`ifdef MAT_INV_DEBUG_EN
  ,
  output logic [DVS_W-1:0]  det,
  output logic              singular
`endif
);

  localparam logic [QUO_W-1:0] Q0_MAX = 32'h7FFF_FFFF;
  localparam logic [QUO_W-1:0] Q1_MAX = 32'h0008_0000;
  localparam logic [QUO_W-1:0] Q2_MAX = 32'h000F_FFFF;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SIG0_W-1:0]        sig0_q, sig0_d;
  logic [SIG1_W-1:0]        sig1_q, sig1_d;
  logic [SIG2_W-1:0]        sig2_q, sig2_d;
  logic signed [DVS_W-1:0]  d_q, d_d;
  logic [OUT0_W-1:0]        out0_q, out0_d;
  logic [OUT1_W-1:0]        out1_q, out1_d;
  logic [OUT2_W-1:0]        out2_q, out2_d;
  logic                     o_valid_q, o_valid_d;

  logic [DVS_W-1:0]         prod_a, prod_b;
  logic signed [DVS_W-1:0]  d_calc;
  logic                     d_bad;
  logic [DVS_W-1:0]         div_dvs;
  logic [QUO_W-1:0]         q0, q1, q2;
  logic                     ovf0, ovf1, ovf2;
  logic [QUO_W-1:0]         mag1, neg1;

  // Both products carry 8 fraction bits, so D is exact at scale 2^8.
  assign prod_a = DVS_W'(sig0_q) * DVS_W'(sig2_q);
  assign prod_b = DVS_W'(sig1_q) * DVS_W'(sig1_q);
  assign d_calc = $signed(prod_a - prod_b);
  assign d_bad  = d_q[DVS_W-1] || (d_q == '0);

  // The overflow compare at init happens in DET, before D is registered.
  assign div_dvs = (state_q == S_DET) ? $unsigned(d_calc) : $unsigned(d_q);

  mat_inv_div u_div0 (
    .clk(clk), .rst_n(rst_n),
    .init(state_q == S_DET), .step(state_q == S_DIV),
    .dividend(DVD_W'(sig2_q) << SH0), .divisor(div_dvs),
    .quotient(q0), .overflow(ovf0)
  );

  mat_inv_div u_div1 (
    .clk(clk), .rst_n(rst_n),
    .init(state_q == S_DET), .step(state_q == S_DIV),
    .dividend(DVD_W'(sig1_q) << SH1), .divisor(div_dvs),
    .quotient(q1), .overflow(ovf1)
  );

  mat_inv_div u_div2 (
    .clk(clk), .rst_n(rst_n),
    .init(state_q == S_DET), .step(state_q == S_DIV),
    .dividend(DVD_W'(sig0_q) << SH2), .divisor(div_dvs),
    .quotient(q2), .overflow(ovf2)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig0_d    = sig0_q;
    sig1_d    = sig1_q;
    sig2_d    = sig2_q;
    d_d       = d_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    o_valid_d = 1'b0;
    mag1      = (ovf1 || (q1 > Q1_MAX)) ? Q1_MAX : q1;
    neg1      = -mag1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sig0_d  = sig0;
          sig1_d  = sig1;
          sig2_d  = sig2;
          state_d = S_DET;
        end
      end
      S_DET: begin
        d_d     = d_calc;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {CNT_W{1'b1}}) state_d = S_DONE;
      end
      S_DONE: begin
        if (d_bad) begin
          out0_d = '0;
          out1_d = '0;
          out2_d = '0;
        end else begin
          out0_d = (ovf0 || (q0 > Q0_MAX)) ? Q0_MAX : q0;
          out1_d = neg1[OUT1_W-1:0];
          out2_d = OUT2_W'((ovf2 || (q2 > Q2_MAX)) ? Q2_MAX : q2);
        end
        o_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sig0_q    <= '0;
      sig1_q    <= '0;
      sig2_q    <= '0;
      d_q       <= '0;
      out0_q    <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sig0_q    <= sig0_d;
      sig1_q    <= sig1_d;
      sig2_q    <= sig2_d;
      d_q       <= d_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign out0    = out0_q;
  assign out1    = out1_q;
  assign out2    = out2_q;
  assign o_valid = o_valid_q;

`ifdef MAT_INV_DEBUG_EN
  logic singular_q, singular_d;

  assign singular_d = (state_q == S_DONE) ? d_bad : singular_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) singular_q <= 1'b0;
    else        singular_q <= singular_d;
  end

  assign det      = $unsigned(d_q);
  assign singular = singular_q;
`endif

endmodule

// File: tb/tb_mat_inv.sv
// tb_mat_inv: directed self-checking bench for mat_inv.
module tb_mat_inv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [20:0] sig0 = '0;
  logic [19:0] sig1 = '0;
  logic [31:0] sig2 = '0;
  logic [31:0] out0;
  logic [19:0] out1;
  logic [20:0] out2;
  logic        o_valid;
`ifdef MAT_INV_DEBUG_EN
  logic [53:0] det;
  logic        singular;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_inv dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .sig0(sig0),
    .sig1(sig1),
    .sig2(sig2),
    .out0(out0),
    .out1(out1),
    .out2(out2),
    .o_valid(o_valid)
`ifdef MAT_INV_DEBUG_EN
    ,
    .det(det),
    .singular(singular)
`endif
  );

  // Issue one request, scramble the inputs right after capture, and return
  // the number of cycles from the capture edge to o_valid (0 = timed out).
  task automatic do_op(input logic [20:0] s0, input logic [19:0] s1,
                       input logic [31:0] s2, output int lat);
    @(negedge clk);
    sig0  = s0;
    sig1  = s1;
    sig2  = s2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sig0  = ~s0;
    sig1  = ~s1;
    sig2  = ~s2;
    lat   = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    #23;
    checks++;
    if (out0 !== 32'h0 || out1 !== 20'h0 || out2 !== 21'h0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out0=%h out1=%h out2=%h v=%b, want all 0",
               out0, out1, out2, o_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_idle_valid: got %0d pulses, want 0", seen);
    end
  endtask

  task automatic test_reference();
    int lat;
    do_op(21'd3, 20'd96, 32'd3584, lat);
    checks++;
    if (lat != 34) begin
      errors++;
      $display("FAIL ref_latency: got %0d, want 34", lat);
    end
    checks++;
    if (out0 !== 32'h0002_5555) begin
      errors++;
      $display("FAIL ref_out0: got %h, want 00025555", out0);
    end
    checks++;
    if (out1 !== 20'hF0000) begin
      errors++;
      $display("FAIL ref_out1: got %h, want f0000", out1);
    end
    checks++;
    if (out2 !== 21'h08000) begin
      errors++;
      $display("FAIL ref_out2: got %h, want 008000", out2);
    end
`ifdef MAT_INV_DEBUG_EN
    checks++;
    if (det !== 54'd1536 || singular !== 1'b0) begin
      errors++;
      $display("FAIL ref_debug: got det=%0d sing=%b, want 1536 0", det, singular);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || out0 !== 32'h0002_5555) begin
      errors++;
      $display("FAIL ref_pulse_hold: got v=%b out0=%h, want 0 00025555", o_valid, out0);
    end
  endtask

  task automatic test_identity();
    int lat;
    do_op(21'd1, 20'd0, 32'd256, lat);
    checks++;
    if (lat != 34 || out0 !== 32'h0001_0000 || out1 !== 20'h0 || out2 !== 21'h10000) begin
      errors++;
      $display("FAIL identity: got lat=%0d out0=%h out1=%h out2=%h, want 34 00010000 00000 010000",
               lat, out0, out1, out2);
    end
  endtask

  task automatic test_singular();
    int lat;
    do_op(21'd1, 20'd16, 32'd256, lat);
    checks++;
    if (lat != 34 || out0 !== 32'h0 || out1 !== 20'h0 || out2 !== 21'h0) begin
      errors++;
      $display("FAIL singular: got lat=%0d out0=%h out1=%h out2=%h, want 34 and all 0",
               lat, out0, out1, out2);
    end
`ifdef MAT_INV_DEBUG_EN
    checks++;
    if (singular !== 1'b1 || det !== 54'd0) begin
      errors++;
      $display("FAIL singular_debug: got sing=%b det=%0d, want 1 0", singular, det);
    end
`endif
  endtask

  task automatic test_saturation();
    int lat;
    do_op(21'd1, 20'd0, 32'd1, lat);
    checks++;
    if (lat != 34 || out0 !== 32'h0001_0000 || out1 !== 20'h0) begin
      errors++;
      $display("FAIL sat_out0_out1: got lat=%0d out0=%h out1=%h, want 34 00010000 00000",
               lat, out0, out1);
    end
    checks++;
    if (out2 !== 21'h0FFFFF) begin
      errors++;
      $display("FAIL sat_out2: got %h, want 0fffff", out2);
    end
    // Large off-diagonal with D = 1: out1 clamps to the most negative value.
    do_op(21'd1, 20'd15, 32'd226, lat);
    checks++;
    if (lat != 34 || out1 !== 20'h80000 || out0 !== 32'h00E2_0000 || out2 !== 21'h0FFFFF) begin
      errors++;
      $display("FAIL sat_out1: got lat=%0d out0=%h out1=%h out2=%h, want 34 00e20000 80000 0fffff",
               lat, out0, out1, out2);
    end
  endtask

  task automatic test_back_to_back();
    int          npulse;
    int          p1;
    int          p2;
    logic [31:0] r0 [2];
    logic [19:0] r1 [2];
    logic [20:0] r2 [2];
    npulse = 0;
    p1 = 0;
    p2 = 0;
    @(negedge clk);
    sig0  = 21'd3;
    sig1  = 20'd96;
    sig2  = 32'd3584;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 75; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        if (npulse < 2) begin
          r0[npulse] = out0;
          r1[npulse] = out1;
          r2[npulse] = out2;
        end
        if (npulse == 0) p1 = i;
        if (npulse == 1) p2 = i;
        npulse++;
      end
      if (i == 10) begin
        sig0 = 21'd1;
        sig1 = 20'd0;
        sig2 = 32'd256;
      end
      if (i == 45) begin
        sig0  = 21'd1;
        sig1  = 20'd16;
        sig2  = 32'd256;
        start = 1'b0;
      end
    end
    checks++;
    if (npulse != 2 || p1 != 34 || p2 != 69) begin
      errors++;
      $display("FAIL b2b_timing: got %0d pulses at %0d,%0d, want 2 at 34,69", npulse, p1, p2);
    end
    if (npulse >= 2) begin
      checks++;
      if (r0[0] !== 32'h0002_5555 || r1[0] !== 20'hF0000 || r2[0] !== 21'h08000) begin
        errors++;
        $display("FAIL b2b_first: got %h %h %h, want 00025555 f0000 008000", r0[0], r1[0], r2[0]);
      end
      checks++;
      if (r0[1] !== 32'h0001_0000 || r1[1] !== 20'h0 || r2[1] !== 21'h10000) begin
        errors++;
        $display("FAIL b2b_second: got %h %h %h, want 00010000 00000 010000", r0[1], r1[1], r2[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    @(negedge clk);
    sig0  = 21'd3;
    sig1  = 20'd96;
    sig2  = 32'd3584;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out0 !== 32'h0 || out1 !== 20'h0 || out2 !== 21'h0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got out0=%h out1=%h out2=%h v=%b, want all 0",
               out0, out1, out2, o_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_no_valid: got %0d pulses, want 0", seen);
    end
    do_op(21'd3, 20'd96, 32'd3584, lat);
    checks++;
    if (lat != 34 || out0 !== 32'h0002_5555 || out1 !== 20'hF0000 || out2 !== 21'h08000) begin
      errors++;
      $display("FAIL midreset_recover: got lat=%0d out0=%h out1=%h out2=%h, want 34 00025555 f0000 008000",
               lat, out0, out1, out2);
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_identity();
    test_singular();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mat_inv.md
# mat_inv

Sequential inverter for the 2×2 symmetric normal-equation matrix [[sig0, sig1], [sig1, sig2]] in the option-pricing regression path. It sits downstream of the XTX accumulator block. It computes the determinant, then uses three restoring divisions to produce the three distinct inverse entries in signed fixed point. Results are registered and announced with a one-cycle `o_valid` pulse.

## Interface
- Parameters: none. All widths and fraction counts are fixed constants in `mat_inv_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level request. Sampled only in IDLE.
- `sig0` in 21: unsigned integer (Q21.0), matrix element [0][0].
- `sig1` in 20: unsigned Q16.4, off-diagonal element.
- `sig2` in 32: unsigned Q24.8, element [1][1].
- `out0` out 32: signed Q16.16, inverse [0][0] = sig2/det.
- `out1` out 20: signed Q4.16, inverse off-diagonal = −sig1/det.
- `out2` out 21: signed Q5.16, inverse [1][1] = sig0/det.
- `o_valid` out 1: one-cycle pulse when the outputs are updated.

## Operation
- States are IDLE → DET → DIV → DONE → IDLE.
- IDLE with `start`=1: capture `sig0`, `sig1` and `sig2` into registers, then go to DET. Input changes after capture are ignored.
- DET: compute D = sig0·sig2 − sig1², signed 54 bits, scaled by 2^8 (exact; both products carry 8 fraction bits). Register D, clear the 5-bit iteration counter, then go to DIV.
- DIV: run three identical restoring dividers in parallel, one quotient bit per cycle for 32 cycles. Advance to DONE when the counter reaches 31.
  - N0 = sig2<<16
  - N1 = sig1<<20
  - N2 = sig0<<24
  - Each divisor is D (unsigned, when D>0).
- Each divider produces a 32-bit truncated quotient plus an overflow flag, set when (N>>32) ≥ D.
- DONE: saturate each quotient to its output width, apply the sign, and register the outputs.
  - out0 = min(Q0, 2^31−1).
  - out2 = min(Q2, 2^20−1).
  - out1 = −min(Q1, 2^19), giving two's complement in 20 bits; the most negative value is 0x80000.
  - Overflow forces saturation.
- Assert `o_valid` for one cycle, then go to IDLE.
- Singular or invalid matrix (D ≤ 0): skip the result. `out0`, `out1` and `out2` all become 0 at DONE, and `o_valid` still pulses.
- Outputs hold their last value between completions.
- `start` during DET, DIV or DONE is ignored. There is no queueing.

## Timing
- Reset: state IDLE, counter 0, all outputs 0, `o_valid` 0. Reset asserted mid-computation aborts the computation; no `o_valid` follows.
- Latency: `start` sampled at edge N → outputs and `o_valid` become 1 at edge N+34 → `o_valid` falls at N+35.
- With `start` held high, a new capture happens at edge N+35. Back-to-back results therefore arrive every 35 cycles.

## Configuration
- `MAT_INV_DEBUG_EN` defined: adds two output ports.
  - `det` out 54: registered D.
  - `singular` out 1: high from DONE onward when D ≤ 0; updated at each DONE.
- `MAT_INV_DEBUG_EN` undefined: these ports and their registers are absent. Functional behavior is identical in both builds.

## Structure
- `mat_inv_pkg` holds:
  - input and output widths;
  - fraction counts (4, 8, 16);
  - dividend and divisor widths (48, 54);
  - quotient width (32);
  - the state enum.
- Sub-module `mat_inv_div`: a one-bit-per-cycle restoring divider with init/step controls, quotient output and overflow flag. It is instantiated three times.

## Test plan
- Reference case:
  - Stimulus: reset; sig0=3, sig1=96 (6.0), sig2=3584 (14.0), `start`=1.
  - Expected: `o_valid` 34 cycles after capture; out0=0x00025555 (2.3333); out1=0xF0000 (−1.0); out2=0x08000 (0.5); debug det=1536.
- Identity:
  - Stimulus: sig0=1, sig1=0, sig2=256.
  - Expected: out0=0x00010000, out1=0, out2=0x10000.
- Singular:
  - Stimulus: sig0=1, sig1=16, sig2=256 (D=0).
  - Expected: all outputs 0; `o_valid` pulses; debug `singular`=1.
- Saturation:
  - Stimulus: sig0=1, sig1=0, sig2=1 (D=1).
  - Expected: out0=0x00010000; out2 saturates to 0x0FFFFF.
- Held `start` / busy:
  - Stimulus: keep `start` high; change the inputs mid-DIV.
  - Expected: `o_valid` pulses exactly every 35 cycles; mid-DIV input changes do not affect the in-flight result.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during DIV.
  - Expected: outputs read 0 immediately; no `o_valid`; the next `start` gives correct results.
